// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode, state and datapath-select encodings for the multicycle sequencer
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_JR   = 6'b000001;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Opcodes that leave DECODE for EXEC rather than completing or faulting there.
  function automatic logic needs_exec(input logic [5:0] op);
    case (op)
      OP_R, OP_BEQ, OP_LW, OP_SW, OP_ADDI: needs_exec = 1'b1;
      default:                             needs_exec = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - saturating memory wait counter; expired once WAIT_MAX idle cycles have elapsed
module mc_wait_timer #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic ready,
  output logic expired
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_MAX);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!ready && (count != LIMIT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - five-stage multicycle control FSM with memory wait timeout and fault trap
module multicycle_sequencer
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src,
  output logic       jal,
  output logic       retire,
  output logic       fault,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic [2:0] state
);

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       retire_q;
  logic       timer_clear;
  logic       timer_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_FETCH;
      op_q     <= '0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      retire_q <= (state_d == ST_FETCH) && (state_q != ST_FETCH);
      if (state_q == ST_DECODE) begin
        op_q <= opcode;
      end
    end
  end

  // Counter only runs while parked in FETCH or MEM; any state change restarts it.
  assign timer_clear = (state_d != state_q) ||
                       !((state_q == ST_FETCH) || (state_q == ST_MEM));

  mc_wait_timer #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .ready  (mem_ready),
    .expired(timer_expired)
  );

  // Strobes are held low while rst_n is asserted so an abandoned instruction cannot touch PC or registers.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    jal        = 1'b0;
    fault      = 1'b0;
    pc_src     = PC_SRC_SEQ;
    alu_op     = ALU_ADD;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = ST_DECODE;
          end else if (timer_expired) begin
            state_d = ST_FAULT;
          end
        end
        ST_DECODE: begin
          case (opcode)
            OP_J: begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_JUMP;
              state_d  = ST_FETCH;
            end
            OP_JAL: begin
              pc_write  = 1'b1;
              pc_src    = PC_SRC_JUMP;
              reg_write = 1'b1;
              jal       = 1'b1;
              state_d   = ST_FETCH;
            end
            OP_JR: begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_REG;
              state_d  = ST_FETCH;
            end
            default: state_d = needs_exec(opcode) ? ST_EXEC : ST_FAULT;
          endcase
        end
        ST_EXEC: begin
          case (op_q)
            OP_BEQ: begin
              alu_op   = ALU_SUB;
              pc_src   = PC_SRC_BRANCH;
              pc_write = zero;
              state_d  = ST_FETCH;
            end
            OP_R: begin
              alu_op  = ALU_FUNCT;
              state_d = ST_WB;
            end
            OP_LW, OP_SW: begin
              alu_src = 1'b1;
              state_d = ST_MEM;
            end
            OP_ADDI: begin
              alu_src = 1'b1;
              state_d = ST_WB;
            end
            default: state_d = ST_FAULT;
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = (op_q == OP_SW);
          if (mem_ready) begin
            state_d = (op_q == OP_SW) ? ST_FETCH : ST_WB;
          end else if (timer_expired) begin
            state_d = ST_FAULT;
          end
        end
        ST_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (op_q == OP_R);
          mem_to_reg = (op_q == OP_LW);
          state_d    = ST_FETCH;
        end
        ST_FAULT: begin
          fault = 1'b1;
        end
        default: state_d = ST_FAULT;
      endcase
    end
  end

  assign retire = retire_q;
  assign state  = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

  localparam int WAIT_MAX = 4;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, ir_write, pc_write, reg_write, reg_dst;
  logic       mem_to_reg, alu_src, jal, retire, fault;
  logic [1:0] pc_src, alu_op;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  multicycle_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .mem_to_reg(mem_to_reg),
    .alu_src   (alu_src),
    .jal       (jal),
    .retire    (retire),
    .fault     (fault),
    .pc_src    (pc_src),
    .alu_op    (alu_op),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (state !== S_FETCH) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, S_FETCH); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL reset_pc_write: got %b want 0", pc_write); end
    checks++; if ({fault, retire} !== 2'b00) begin errors++; $display("FAIL reset_fault_retire: got %b want 00", {fault, retire}); end
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++; if ({state, mem_req, retire} !== {S_FETCH, 1'b1, 1'b0}) begin errors++; $display("FAIL release_fetch: got st=%0d req=%b ret=%b want st=0 req=1 ret=0", state, mem_req, retire); end
  endtask

  task automatic test_r_type();
    opcode = 6'b000000; mem_ready = 1'b1;
    #1;
    checks++; if ({ir_write, pc_write, pc_src} !== 4'b1100) begin errors++; $display("FAIL r_fetch_strobes: got %b want 1100", {ir_write, pc_write, pc_src}); end
    cyc();
    checks++; if ({state, pc_write} !== {S_DECODE, 1'b0}) begin errors++; $display("FAIL r_decode: got st=%0d pcw=%b want st=1 pcw=0", state, pc_write); end
    cyc();
    checks++; if ({state, alu_op, alu_src} !== {S_EXEC, 2'b10, 1'b0}) begin errors++; $display("FAIL r_exec: got st=%0d op=%b src=%b want st=2 op=10 src=0", state, alu_op, alu_src); end
    cyc();
    checks++; if ({state, reg_write, reg_dst, mem_to_reg} !== {S_WB, 3'b110}) begin errors++; $display("FAIL r_wb: got st=%0d rw/rd/m2r=%b want st=4 110", state, {reg_write, reg_dst, mem_to_reg}); end
    cyc();
    checks++; if ({state, retire} !== {S_FETCH, 1'b1}) begin errors++; $display("FAIL r_retire: got st=%0d ret=%b want st=0 ret=1", state, retire); end
  endtask

  task automatic test_addi();
    int n;
    opcode = 6'b001000; mem_ready = 1'b1;
    cyc(); cyc();
    checks++; if ({state, alu_src, alu_op} !== {S_EXEC, 1'b1, 2'b00}) begin errors++; $display("FAIL addi_exec: got st=%0d src=%b op=%b want st=2 src=1 op=00", state, alu_src, alu_op); end
    cyc();
    checks++; if ({state, reg_write, reg_dst, mem_to_reg} !== {S_WB, 3'b100}) begin errors++; $display("FAIL addi_wb: got st=%0d %b want st=4 100", state, {reg_write, reg_dst, mem_to_reg}); end
    n = 3;
    while (state !== S_FETCH && n < 20) begin cyc(); n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL addi_cpi: got %0d want 4", n); end
  endtask

  task automatic test_lw_wait();
    int n;
    opcode = 6'b100011; mem_ready = 1'b1; n = 0;
    cyc(); n++;
    cyc(); n++;
    cyc(); n++;
    mem_ready = 1'b0;
    #1;
    checks++; if ({state, mem_req, mem_we} !== {S_MEM, 2'b10}) begin errors++; $display("FAIL lw_mem: got st=%0d req=%b we=%b want st=3 req=1 we=0", state, mem_req, mem_we); end
    cyc(); n++;
    cyc(); n++;
    checks++; if (state !== S_MEM) begin errors++; $display("FAIL lw_wait_hold: got %0d want %0d", state, S_MEM); end
    mem_ready = 1'b1;
    cyc(); n++;
    checks++; if ({state, reg_write, mem_to_reg, reg_dst} !== {S_WB, 3'b110}) begin errors++; $display("FAIL lw_wb: got st=%0d rw/m2r/rd=%b want st=4 110", state, {reg_write, mem_to_reg, reg_dst}); end
    cyc(); n++;
    checks++; if ({state, retire} !== {S_FETCH, 1'b1} || n != 7) begin errors++; $display("FAIL lw_cycles: got st=%0d ret=%b n=%0d want st=0 ret=1 n=7", state, retire, n); end
  endtask

  task automatic test_beq();
    for (int z = 0; z < 2; z++) begin
      opcode = 6'b000100; mem_ready = 1'b1; zero = z[0];
      cyc(); cyc();
      checks++; if ({state, pc_write, pc_src, alu_op} !== {S_EXEC, z[0], 2'b01, 2'b01}) begin errors++; $display("FAIL beq_exec_z%0d: got st=%0d pcw=%b src=%b op=%b want st=2 pcw=%0d src=01 op=01", z, state, pc_write, pc_src, alu_op, z); end
      cyc();
      checks++; if ({state, retire} !== {S_FETCH, 1'b1}) begin errors++; $display("FAIL beq_retire_z%0d: got st=%0d ret=%b want st=0 ret=1", z, state, retire); end
    end
    zero = 1'b0;
  endtask

  task automatic test_jumps();
    logic [5:0] ops [3];
    logic [1:0] srcs [3];
    logic       links [3];
    ops = '{6'b000010, 6'b000011, 6'b000001};
    srcs = '{2'b10, 2'b10, 2'b11};
    links = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      opcode = ops[i]; mem_ready = 1'b1;
      cyc();
      checks++; if ({state, pc_write, pc_src, jal, reg_write} !== {S_DECODE, 1'b1, srcs[i], links[i], links[i]}) begin errors++; $display("FAIL jump_decode_%0d: got st=%0d pcw=%b src=%b jal=%b rw=%b want src=%b link=%b", i, state, pc_write, pc_src, jal, reg_write, srcs[i], links[i]); end
      cyc();
      checks++; if ({state, retire} !== {S_FETCH, 1'b1}) begin errors++; $display("FAIL jump_retire_%0d: got st=%0d ret=%b want st=0 ret=1", i, state, retire); end
    end
  endtask

  task automatic test_sw_reset();
    opcode = 6'b101011; mem_ready = 1'b1;
    cyc(); cyc(); cyc();
    mem_ready = 1'b0;
    #1;
    checks++; if ({state, mem_req, mem_we} !== {S_MEM, 2'b11}) begin errors++; $display("FAIL sw_mem: got st=%0d req=%b we=%b want st=3 11", state, mem_req, mem_we); end
    rst_n = 1'b0;
    #1;
    checks++; if ({state, mem_req, mem_we, pc_write} !== {S_FETCH, 3'b000}) begin errors++; $display("FAIL sw_reset_drop: got st=%0d req/we/pcw=%b want st=0 000", state, {mem_req, mem_we, pc_write}); end
    cyc();
    rst_n = 1'b1;
    #1;
    checks++; if ({state, mem_req, mem_we, pc_write, retire} !== {S_FETCH, 4'b1000}) begin errors++; $display("FAIL sw_release: got st=%0d req/we/pcw/ret=%b want st=0 1000", state, {mem_req, mem_we, pc_write, retire}); end
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if ({state, mem_we, pc_write, reg_write} !== {S_FETCH, 3'b000}) begin errors++; $display("FAIL sw_post_release_%0d: got st=%0d we/pcw/rw=%b want st=0 000", i, state, {mem_we, pc_write, reg_write}); end
    end
    opcode = 6'b000010; mem_ready = 1'b1;
    #1;
    checks++; if ({pc_write, ir_write} !== 2'b11) begin errors++; $display("FAIL sw_refetch: got %b want 11", {pc_write, ir_write}); end
    cyc(); cyc();
  endtask

  task automatic test_fetch_timeout();
    mem_ready = 1'b0;
    repeat (WAIT_MAX) cyc();
    checks++; if ({state, fault} !== {S_FETCH, 1'b0}) begin errors++; $display("FAIL tmo_edge_hold: got st=%0d flt=%b want st=0 flt=0", state, fault); end
    mem_ready = 1'b1;
    cyc();
    checks++; if (state !== S_DECODE) begin errors++; $display("FAIL tmo_ready_wins: got %0d want %0d", state, S_DECODE); end
    opcode = 6'b000010;
    cyc();
    mem_ready = 1'b0;
    repeat (WAIT_MAX) cyc();
    checks++; if (state !== S_FETCH) begin errors++; $display("FAIL tmo_before: got %0d want %0d", state, S_FETCH); end
    cyc();
    checks++; if ({state, fault, mem_req} !== {S_FAULT, 2'b10}) begin errors++; $display("FAIL tmo_fault: got st=%0d flt=%b req=%b want st=5 10", state, fault, mem_req); end
    rst_n = 1'b0;
    #1;
    checks++; if ({state, fault} !== {S_FETCH, 1'b0}) begin errors++; $display("FAIL tmo_reset_clear: got st=%0d flt=%b want st=0 0", state, fault); end
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_bad_opcode();
    opcode = 6'b111111; mem_ready = 1'b1;
    cyc();
    checks++; if (state !== S_DECODE) begin errors++; $display("FAIL bad_decode: got %0d want %0d", state, S_DECODE); end
    cyc();
    checks++; if ({state, fault, pc_write, reg_write} !== {S_FAULT, 3'b100}) begin errors++; $display("FAIL bad_fault: got st=%0d flt/pcw/rw=%b want st=5 100", state, {fault, pc_write, reg_write}); end
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      opcode = (i[1]) ? 6'b000010 : 6'b000000;
      cyc();
      checks++; if ({state, fault, mem_req, pc_write, retire} !== {S_FAULT, 4'b1000}) begin errors++; $display("FAIL bad_absorb_%0d: got st=%0d flt/req/pcw/ret=%b want st=5 1000", i, state, {fault, mem_req, pc_write, retire}); end
    end
    rst_n = 1'b0;
    #1;
    checks++; if ({state, fault} !== {S_FETCH, 1'b0}) begin errors++; $display("FAIL bad_reset_clear: got st=%0d flt=%b want st=0 0", state, fault); end
    cyc();
    rst_n = 1'b1;
    mem_ready = 1'b0;
    #1;
    checks++; if ({state, mem_req, fault} !== {S_FETCH, 2'b10}) begin errors++; $display("FAIL bad_release: got st=%0d req=%b flt=%b want st=0 10", state, mem_req, fault); end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_addi();
    test_lw_wait();
    test_beq();
    test_jumps();
    test_sw_reset();
    test_fetch_timeout();
    test_bad_opcode();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
